// File: rtl/latch_pkg.sv
// Shared definitions for the d_latch driver: FSM state encoding and default phase timing.
// The default timing set is also used by the d_latch bench so both agree on window sizes.
package latch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_OPEN_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_CNT_W     = 4;

    // Counter reload value for a phase of cyc cycles; an empty phase reloads 0.
    function automatic int phase_load(input int cyc);
        return (cyc > 0) ? cyc - 1 : 0;
    endfunction

endpackage

// File: rtl/latch_strobe_gen_phase_counter.sv
// Down-counter that times one FSM phase; zero flags the last cycle of the phase.
// Decrement saturates at zero so the count can never wrap.
module phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_strobe_gen.sv
// Drives a transparent d_latch from a valid/ready stream: D is set up, enable is pulsed,
// then D is held, so the latch never sees D move while enable is high.
module latch_strobe_gen
    import latch_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int OPEN_CYC  = DEF_OPEN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic             enable,
    output logic             busy,
    output logic             done
);

    if (OPEN_CYC < 1 || SETUP_CYC < 0 || HOLD_CYC < 0 ||
        SETUP_CYC >= (1 << CNT_W) || OPEN_CYC >= (1 << CNT_W) ||
        HOLD_CYC >= (1 << CNT_W)) begin : g_bad_params
        $error("latch_strobe_gen: illegal phase timing parameters");
    end

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(phase_load(SETUP_CYC));
    localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(phase_load(OPEN_CYC));
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(phase_load(HOLD_CYC));

    state_t           state;
    logic             accept;
    logic             load;
    logic             dec;
    logic [CNT_W-1:0] load_val;
    logic             zero;

    assign accept = in_valid & in_ready;

    // Counter control: reload on every phase entry, count down while a phase runs.
    always_comb begin
        load     = 1'b0;
        dec      = 1'b0;
        load_val = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load     = 1'b1;
                    load_val = (SETUP_CYC > 0) ? SETUP_LOAD : OPEN_LOAD;
                end
            end
            SETUP: begin
                if (zero) begin
                    load     = 1'b1;
                    load_val = OPEN_LOAD;
                end else begin
                    dec = 1'b1;
                end
            end
            OPEN: begin
                if (zero) begin
                    load     = 1'b1;
                    load_val = (HOLD_CYC > 0) ? HOLD_LOAD : '0;
                end else begin
                    dec = 1'b1;
                end
            end
            HOLD: begin
                if (zero) begin
                    load     = 1'b1;
                    load_val = '0;
                end else begin
                    dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    // Outputs are updated together with the state so enable is a clean flop output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            D        <= '0;
            enable   <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        D        <= in_data;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (SETUP_CYC > 0) begin
                            state <= SETUP;
                        end else begin
                            state  <= OPEN;
                            enable <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (zero) begin
                        state  <= OPEN;
                        enable <= 1'b1;
                    end
                end
                OPEN: begin
                    if (zero) begin
                        enable <= 1'b0;
                        if (HOLD_CYC > 0) begin
                            state <= HOLD;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (zero) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
